// File: rtl/button_conditioner_pkg.sv
// Shared types, 25 MHz timing defaults and width helper for button_conditioner.
// Auto-repeat is built only when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // 500 ms and 100 ms at 25 MHz
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_REPEAT_DELAY  = 12_500_000;
    localparam int DEF_REPEAT_PERIOD = 2_500_000;

    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop sync, two-way debounce, press/release pulses, repeat FSM.
// Repeat FSM and timer exist only with BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic press,
    output logic rel,
    output logic act
);

    localparam int CW = width_for(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_channel: timing parameters must be >= 1");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          flip;
    logic          press_d;
    logic          rel_d;

    assign flip    = (s2 != level) && (cnt == CNT_LAST);
    assign press_d = flip & ~level;
    assign rel_d   = flip & level;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= in;
            s2    <= s1;
            cnt   <= (s2 == level || flip) ? '0 : cnt + 1'b1;
            level <= level ^ flip;
            press <= press_d;
            rel   <= rel_d;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN

    localparam int TW = width_for(
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    rpt_state_t    state;
    rpt_state_t    state_d;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_d;
    logic          due;
    logic          act_d;

    assign due = (state == RPT_DELAY  && tcnt == DLY_LAST) ||
                 (state == RPT_REPEAT && tcnt == PER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RPT_IDLE;
            tcnt  <= '0;
            act   <= 1'b0;
        end else begin
            state <= state_d;
            tcnt  <= tcnt_d;
            act   <= act_d;
        end
    end

    always_comb begin
        state_d = state;
        tcnt_d  = tcnt;
        unique case (state)
            RPT_IDLE: begin
                if (press_d) begin
                    state_d = RPT_DELAY;
                    tcnt_d  = '0;
                end
            end
            RPT_DELAY, RPT_REPEAT: begin
                if (due) begin
                    state_d = RPT_REPEAT;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            default: begin
                state_d = RPT_IDLE;
                tcnt_d  = '0;
            end
        endcase
        if (rel_d) begin
            state_d = RPT_IDLE;
            tcnt_d  = '0;
        end
    end

    // a repeat landing on the debounced fall is dropped
    always_comb begin
        act_d = press_d | (due & ~rel_d);
    end

`else

    assign act = press;

`endif

endmodule

// File: rtl/button_conditioner.sv
// N_CH-wide button conditioner: one button_channel per raw input.
// Auto-repeat on act is enabled by BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] rel,
    output logic [N_CH-1:0] act
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .in   (in[i]),
            .level(level[i]),
            .press(press[i]),
            .rel  (rel[i]),
            .act  (act[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (N_CH=5, STABLE=4, DELAY=20, PERIOD=8).
// Expected act follows BUTTON_CONDITIONER_AUTOREPEAT_EN.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] in;
    logic [4:0] level;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] act;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    always #5 clk = ~clk;

    button_conditioner #(
        .N_CH         (5),
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .level(level),
        .press(press),
        .rel  (rel),
        .act  (act)
    );

    task automatic do_reset();
        rst = 1'b1;
        in  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in  = '1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({level, press, rel, act} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset e=%0d got %h want 00000", e,
                         {level, press, rel, act});
            end
        end
        do_reset();
    endtask

    task automatic test_clean_press();
        logic [19:0] exp;
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            in    = '0;
            in[0] = (e >= 10 && e < 30);
            @(posedge clk);
            #1;
            exp = '0;
            exp[15] = (e >= 15 && e < 35);
            exp[10] = (e == 15);
            exp[5]  = (e == 35);
            exp[0]  = (e == 15);
            n_checks++;
            if ({level, press, rel, act} !== exp) begin
                n_fail++;
                $display("FAIL clean_press e=%0d got %h want %h", e,
                         {level, press, rel, act}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [19:0] exp;
        do_reset();
        for (int e = 1; e <= 55; e++) begin
            in    = '0;
            in[1] = (e >= 10 && e <= 12) || (e >= 40 && e <= 43);
            @(posedge clk);
            #1;
            exp = '0;
            exp[16] = (e >= 45 && e < 49);
            exp[11] = (e == 45);
            exp[6]  = (e == 49);
            exp[1]  = (e == 45);
            n_checks++;
            if ({level, press, rel, act} !== exp) begin
                n_fail++;
                $display("FAIL glitch e=%0d got %h want %h", e,
                         {level, press, rel, act}, exp);
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [19:0] exp;
        do_reset();
        for (int e = 1; e <= 85; e++) begin
            in    = '0;
            in[2] = (e >= 10 && e <= 65);
            @(posedge clk);
            #1;
            exp = '0;
            exp[17] = (e >= 15 && e < 71);
            exp[12] = (e == 15);
            exp[7]  = (e == 71);
            exp[2]  = (e == 15) || (RPT && (e == 35 || e == 43 ||
                      e == 51 || e == 59 || e == 67));
            n_checks++;
            if ({level, press, rel, act} !== exp) begin
                n_fail++;
                $display("FAIL hold_repeat e=%0d got %h want %h", e,
                         {level, press, rel, act}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [19:0] exp;
        do_reset();
        for (int e = 1; e <= 76; e++) begin
            in    = '0;
            in[3] = (e >= 10);
            rst   = (e == 40);
            @(posedge clk);
            #1;
            exp = '0;
            exp[18] = (e >= 15 && e < 40) || (e >= 46);
            exp[13] = (e == 15) || (e == 46);
            exp[3]  = (e == 15) || (e == 46) ||
                      (RPT && (e == 35 || e == 66 || e == 74));
            n_checks++;
            if ({level, press, rel, act} !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_hold e=%0d got %h want %h", e,
                         {level, press, rel, act}, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [19:0] exp;
        do_reset();
        for (int e = 1; e <= 70; e++) begin
            in    = '0;
            in[0] = (e >= 10 && e < 60);
            in[4] = (e >= 10 && e < 25);
            @(posedge clk);
            #1;
            exp = '0;
            exp[15] = (e >= 15 && e < 65);
            exp[19] = (e >= 15 && e < 30);
            exp[10] = (e == 15);
            exp[14] = (e == 15);
            exp[5]  = (e == 65);
            exp[9]  = (e == 30);
            exp[0]  = (e == 15) || (RPT && (e == 35 || e == 43 ||
                      e == 51 || e == 59));
            exp[4]  = (e == 15);
            n_checks++;
            if ({level, press, rel, act} !== exp) begin
                n_fail++;
                $display("FAIL simultaneous e=%0d got %h want %h", e,
                         {level, press, rel, act}, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in  = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_hold_repeat();
        test_reset_mid_hold();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel successor to the per-button debounce/one-pulse logic: one instance conditions all N_CH raw push-buttons.
- Per channel: two-flop synchroniser, counter-based debounce in both directions, press/release one-cycle pulses, hold-to-repeat action pulses.
- Sits between board pins and the cursor/`enter` consumers. It runs on the 25 MHz domain; `act` drives the cursor-move logic directly.

Parameters:
- N_CH, 5, number of independent button channels.
- STABLE_CYCLES, 8, consecutive cycles a synchronised input must disagree with the debounced level before the level flips (>=1).
- REPEAT_DELAY, 12_500_000, cycles from press to first repeat pulse (>=1).
- REPEAT_PERIOD, 2_500_000, cycles between subsequent repeat pulses (>=1).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in, input, N_CH, raw asynchronous button levels (1 = pressed).
- level, output, N_CH, debounced registered level.
- press, output, N_CH, one-cycle pulse on debounced 0->1.
- release, output, N_CH, one-cycle pulse on debounced 1->0.
- act, output, N_CH, one-cycle pulse: press OR repeat.

Behaviour:
- Reset: rst sampled high at an edge clears synchroniser flops, counters, FSM state, and all outputs to 0. Reset mid-hold behaves as power-up: a still-held button re-debounces and produces a fresh press.
- Synchroniser: s = in delayed two flops.
- Debounce counter (width clog2(STABLE_CYCLES+1)):
  - Cleared whenever s == level.
  - Incremented when s != level.
  - When s != level and cnt == STABLE_CYCLES-1: level toggles at that edge and cnt clears.
- Latency: raw change first sampled at edge k and held => level/press (or release) change at edge k+1+STABLE_CYCLES.
- Glitch rejection: pulses shorter than STABLE_CYCLES cycles after sync produce no output change.
- press/release are registered and coincident with the level edge; each is high exactly one cycle.
- Repeat FSM per channel: IDLE -> DELAY -> REPEAT.
  - IDLE -> DELAY on press; tcnt = 0.
  - DELAY: tcnt counts. At tcnt == REPEAT_DELAY-1, act pulses, tcnt clears, go to REPEAT.
  - REPEAT: act pulses every REPEAT_PERIOD cycles.
  - Any state -> IDLE on release. A repeat due on the same edge as the debounced fall is suppressed.
- Timer width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1); the timer never wraps.
- Channels are fully independent; simultaneous events on several channels all produce their own pulses in the same cycle. No cross-channel priority.
- No combinational path from `in` to any output.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTOREPEAT_EN.
- Defined: repeat FSM and timer present as above.
- Undefined: FSM and timer are not compiled. act == press. REPEAT_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Shared package:
  - Repeat-FSM state enum (IDLE/DELAY/REPEAT, 2 bits).
  - Default timing constants for 25 MHz (500 ms delay, 100 ms period).
  - Width helper function.
- One sub-module, button_channel: synchroniser + debounce + repeat FSM for a single channel, parametrised identically.
- Top: generate loop instantiating N_CH copies.

Test Plan:
All scenarios use N_CH=5, STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, macro defined unless stated.
- Clean press: in[0] rises, first sampled at edge 10, held -> level[0]=1, press[0]=act[0]=1 at edge 15 only; release of in[0] first sampled at edge 30 -> release[0] at edge 35, level[0]=0.
- Glitch: in[1] high for 3 cycles -> level, press, release, act on ch1 stay 0 throughout.
- Hold-repeat: in[2] high, sampled edges 10..65, falls sampled at 66 -> press at 15; act at 15, 35, 43, 51, 59, 67; release at 71; no act after 67.
- Reset mid-hold: in[3] held from edge 10, rst high at edge 40 only -> all outputs 0 after edge 40; press[3] again at edge 46; repeat timing restarts from 46 (first repeat at 66).
- Simultaneous: in[0] and in[4] rise sampled at the same edge 10 -> press[0] and press[4] both at edge 15; release of ch4 does not affect ch0 repeats.
- Macro undefined: scenario 3 stimulus -> act[2] pulses only at edge 15; press/release/level timing unchanged.
